// File: rtl/lm70_spi_sequencer.sv
// LM70 temperature-sensor SPI read sequencer.
// Runs one read frame per request (from the start input or the periodic auto
// timer): chip-select setup, FRAME_BITS SCK pulses sampling sio MSB first,
// then a chip-select hold gap. The captured frame is left-aligned into
// temp_raw and decoded into an integer temperature and sign.
// Optional build macro LM70_SPI_SEQUENCER_AVG_EN: report the mean of every
// 4 consecutive frames instead of each frame.
module lm70_spi_sequencer #(
    parameter int SCK_DIV     = 2,
    parameter int FRAME_BITS  = 16,
    parameter int CS_SETUP    = 4,
    parameter int CS_HOLD     = 4,
    parameter int AUTO_PERIOD = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        auto_en,
    input  logic        sio,
    output logic        cs_n,
    output logic        sck,
    output logic        busy,
    output logic        temp_valid,
    output logic [15:0] temp_raw,
    output logic [7:0]  temp_int,
    output logic        temp_neg
);

    // The phase counter is shared by SETUP, SHIFT (one SCK period) and HOLD,
    // so it must cover the longest of the three.
    localparam int CNT_MAX = (CS_SETUP > CS_HOLD)
                           ? ((CS_SETUP > 2*SCK_DIV) ? CS_SETUP : 2*SCK_DIV)
                           : ((CS_HOLD  > 2*SCK_DIV) ? CS_HOLD  : 2*SCK_DIV);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int AUTO_W  = $clog2(AUTO_PERIOD + 1);
    localparam int ALIGN   = 16 - FRAME_BITS;

    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0]  SCK_RISE   = CNT_W'(SCK_DIV - 1);
    localparam logic [CNT_W-1:0]  SCK_FALL   = CNT_W'(2*SCK_DIV - 1);
    localparam logic [4:0]        BIT_LAST   = 5'(FRAME_BITS - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST  = AUTO_W'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    // Negative readings clamp to 0; otherwise bits 14:7 are whole degrees
    // (LM70 LSB is 0.25 C at bit 5 of the left-aligned word).
    function automatic logic [7:0] sat_int(input logic [15:0] raw);
        return raw[15] ? 8'd0 : raw[14:7];
    endfunction

`ifdef LM70_SPI_SEQUENCER_AVG_EN
    // Mean of four: arithmetic shift of the signed sum, truncating.
    function automatic logic [15:0] avg4(input logic signed [17:0] sum);
        logic signed [17:0] q;
        q = sum >>> 2;
        return q[15:0];
    endfunction
`endif

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [4:0]          bit_q;
    logic [15:0]         shift_q;
    logic                pend_q;
    logic [AUTO_W-1:0]   acnt_q;
    logic                cs_n_q;
    logic                sck_q;
    logic                busy_q;
    logic                tvalid_q;
    logic [15:0]         temp_raw_q;
    logic                auto_hit;
    logic [15:0]         frame_raw_d;

`ifdef LM70_SPI_SEQUENCER_AVG_EN
    logic signed [17:0]  acc_q;
    logic signed [17:0]  acc_sum_d;
    logic [1:0]          fcnt_q;

    assign acc_sum_d = acc_q + {{2{frame_raw_d[15]}}, frame_raw_d};
`endif

    assign auto_hit    = auto_en && (acnt_q == AUTO_LAST);
    assign frame_raw_d = shift_q << ALIGN;

    // Free-running auto-request timer, held at zero while auto_en is low.
    always_ff @(posedge clk) begin
        if (rst || !auto_en) begin
            acnt_q <= '0;
        end else if (auto_hit) begin
            acnt_q <= '0;
        end else begin
            acnt_q <= acnt_q + AUTO_W'(1);
        end
    end

    // Frame sequencer: state, pending auto request, shifter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            pend_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sck_q      <= 1'b0;
            busy_q     <= 1'b0;
            tvalid_q   <= 1'b0;
            temp_raw_q <= '0;
`ifdef LM70_SPI_SEQUENCER_AVG_EN
            acc_q      <= '0;
            fcnt_q     <= '0;
`endif
        end else begin
            tvalid_q <= 1'b0;
            // Auto requests arriving mid-frame collapse into one pending flag.
            if (state_q != IDLE && auto_hit) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start || pend_q || auto_hit) begin
                        state_q <= SETUP;
                        cnt_q   <= '0;
                        shift_q <= '0;
                        pend_q  <= 1'b0;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    // sio is captured on the edge that raises SCK.
                    if (cnt_q == SCK_RISE) begin
                        sck_q   <= 1'b1;
                        shift_q <= {shift_q[14:0], sio};
                    end
                    if (cnt_q == SCK_FALL) begin
                        sck_q <= 1'b0;
                        cnt_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            state_q <= HOLD;
                            cs_n_q  <= 1'b1;
`ifdef LM70_SPI_SEQUENCER_AVG_EN
                            if (fcnt_q == 2'd3) begin
                                temp_raw_q <= avg4(acc_sum_d);
                                tvalid_q   <= 1'b1;
                                acc_q      <= '0;
                                fcnt_q     <= '0;
                            end else begin
                                acc_q  <= acc_sum_d;
                                fcnt_q <= fcnt_q + 2'd1;
                            end
`else
                            temp_raw_q <= frame_raw_d;
                            tvalid_q   <= 1'b1;
`endif
                        end else begin
                            bit_q <= bit_q + 5'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Dropping auto_en discards any pending auto request.
            if (!auto_en) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign cs_n       = cs_n_q;
    assign sck        = sck_q;
    assign busy       = busy_q;
    assign temp_valid = tvalid_q;
    assign temp_raw   = temp_raw_q;
    assign temp_int   = sat_int(temp_raw_q);
    assign temp_neg   = temp_raw_q[15];

endmodule

// File: tb/tb_lm70_spi_sequencer.sv
// Self-checking bench for lm70_spi_sequencer: a time-offset frame model,
// per-cycle output comparison, directed literal checks and random stimulus.
module tb_lm70_spi_sequencer;

    localparam int SCK_DIV    = 2;
    localparam int FRAME_BITS = 16;
    localparam int CS_SETUP   = 4;
    localparam int CS_HOLD    = 4;
    localparam int AUTO_P     = 50;
    localparam int SHIFTC     = 2 * SCK_DIV * FRAME_BITS;
    localparam int T_CAP      = CS_SETUP + SHIFTC;
    localparam int T_TOTAL    = T_CAP + CS_HOLD;

    logic        clk = 1'b0;
    logic        rst, start, auto_en, sio;
    logic        cs_n, sck, busy, temp_valid, temp_neg;
    logic [15:0] temp_raw;
    logic [7:0]  temp_int;

    lm70_spi_sequencer #(
        .SCK_DIV(SCK_DIV), .FRAME_BITS(FRAME_BITS), .CS_SETUP(CS_SETUP),
        .CS_HOLD(CS_HOLD), .AUTO_PERIOD(AUTO_P)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .sio(sio),
        .cs_n(cs_n), .sck(sck), .busy(busy), .temp_valid(temp_valid),
        .temp_raw(temp_raw), .temp_int(temp_int), .temp_neg(temp_neg)
    );

    always #5 clk = ~clk;

    // Model: m_t is the cycle offset inside the current frame (-1 = idle).
    int          m_t    = -1;
    bit          m_pend = 1'b0;
    int          m_acnt = 0;
    bit [15:0]   m_raw  = '0;
    bit [15:0]   m_word = '0;
    bit          m_valid = 1'b0;
    int          m_acc  = 0;
    int          m_n    = 0;
    bit          m_hit;
    bit [15:0]   next_word = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_t = -1; m_pend = 0; m_acnt = 0; m_raw = '0; m_valid = 0;
            m_acc = 0; m_n = 0;
        end else begin
            m_hit = auto_en && (m_acnt == AUTO_P - 1);
            if (!auto_en || m_hit) m_acnt = 0;
            else m_acnt = m_acnt + 1;
            m_valid = 0;
            if (m_t < 0) begin
                if (start || m_pend || m_hit) begin
                    m_t = 0; m_pend = 0; m_word = next_word;
                end
            end else begin
                if (m_hit) m_pend = 1;
                m_t = m_t + 1;
                if (m_t == T_CAP) begin
`ifdef LM70_SPI_SEQUENCER_AVG_EN
                    m_acc = m_acc + int'($signed(m_word));
                    m_n = m_n + 1;
                    if (m_n == 4) begin
                        m_raw = 16'(m_acc >>> 2);
                        m_valid = 1;
                        m_acc = 0; m_n = 0;
                    end
`else
                    m_raw = m_word;
                    m_valid = 1;
`endif
                end
                if (m_t == T_TOTAL) m_t = -1;
            end
            if (!auto_en) m_pend = 0;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int cs_low = 0, sck_rise = 0, vld_cnt = 0, busy_cnt = 0;
    logic prev_sck = 1'b0, prev_cs = 1'b1;
    int starts[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // One clock: compare DUT against model, update monitors, drive sio.
    task automatic step();
        bit e_cs, e_sck, e_busy, e_neg;
        bit [7:0] e_int;
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            e_cs   = !(m_t >= 0 && m_t < T_CAP);
            e_sck  = (m_t >= CS_SETUP) && (m_t < T_CAP) && (((m_t - CS_SETUP) % (2*SCK_DIV)) >= SCK_DIV);
            e_busy = (m_t >= 0);
            e_neg  = (int'(m_raw) >= 32768);
            e_int  = e_neg ? 8'd0 : 8'((int'(m_raw) / 128) % 256);
            n_cmp++;
            if (cs_n !== e_cs || sck !== e_sck || busy !== e_busy || temp_valid !== m_valid ||
                temp_raw !== m_raw || temp_int !== e_int || temp_neg !== e_neg) begin
                n_err++;
                $display("FAIL cycle %0d: got cs_n=%b sck=%b busy=%b vld=%b raw=%h int=%0d neg=%b, want cs_n=%b sck=%b busy=%b vld=%b raw=%h int=%0d neg=%b",
                         cyc, cs_n, sck, busy, temp_valid, temp_raw, temp_int, temp_neg,
                         e_cs, e_sck, e_busy, m_valid, m_raw, e_int, e_neg);
            end
        end
        if (cs_n === 1'b0) cs_low++;
        if (sck === 1'b1 && prev_sck === 1'b0) sck_rise++;
        if (temp_valid === 1'b1) vld_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (cs_n === 1'b0 && prev_cs === 1'b1) starts.push_back(cyc);
        prev_sck = sck;
        prev_cs  = cs_n;
        if (m_t >= CS_SETUP && m_t < T_CAP) sio = m_word[15 - (m_t - CS_SETUP) / (2*SCK_DIV)];
        else sio = 1'($urandom_range(0, 1));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int c0, s0, v0, b0, f0;
`ifdef LM70_SPI_SEQUENCER_AVG_EN
    logic [15:0] avgw [4] = '{16'h0C00, 16'h0C80, 16'h0D00, 16'h0D80};
`endif

    initial begin
        rst = 1'b1; start = 1'b0; auto_en = 1'b0; sio = 1'b0;
        run(3);
        chk_en = 1'b1;
        check("reset cs_n", 32'(cs_n), 1);
        check("reset sck", 32'(sck), 0);
        check("reset busy", 32'(busy), 0);
        check("reset temp_valid", 32'(temp_valid), 0);
        check("reset temp_raw", 32'(temp_raw), 0);
        rst = 1'b0;
        run(2);

`ifdef LM70_SPI_SEQUENCER_AVG_EN
        v0 = vld_cnt;
        for (int i = 0; i < 4; i++) begin
            next_word = avgw[i];
            pulse_start();
            run(80);
        end
        check("avg valid pulses", 32'(vld_cnt - v0), 1);
        check("avg temp_raw", 32'(temp_raw), 32'h0CC0);
        check("avg temp_int", 32'(temp_int), 25);
        check("avg temp_neg", 32'(temp_neg), 0);
`else
        next_word = 16'h0C80;
        c0 = cs_low; s0 = sck_rise; v0 = vld_cnt; b0 = busy_cnt;
        pulse_start();
        run(80);
        check("f1 cs_n low cycles", 32'(cs_low - c0), 68);
        check("f1 sck pulses", 32'(sck_rise - s0), 16);
        check("f1 valid pulses", 32'(vld_cnt - v0), 1);
        check("f1 busy cycles", 32'(busy_cnt - b0), 72);
        check("f1 temp_raw", 32'(temp_raw), 32'h0C80);
        check("f1 temp_int", 32'(temp_int), 25);
        check("f1 temp_neg", 32'(temp_neg), 0);

        next_word = 16'hF380;
        c0 = cs_low; v0 = vld_cnt; b0 = busy_cnt; f0 = starts.size();
        pulse_start();
        run(9);
        pulse_start();
        run(19);
        pulse_start();
        run(60);
        check("f2 frames started", 32'(starts.size() - f0), 1);
        check("f2 busy cycles", 32'(busy_cnt - b0), 72);
        check("f2 cs_n low cycles", 32'(cs_low - c0), 68);
        check("f2 valid pulses", 32'(vld_cnt - v0), 1);
        check("f2 temp_raw", 32'(temp_raw), 32'hF380);
        check("f2 temp_neg", 32'(temp_neg), 1);
        check("f2 temp_int", 32'(temp_int), 0);
`endif

        // Abort in the middle of SHIFT.
        next_word = 16'($urandom);
        v0 = vld_cnt;
        pulse_start();
        run(CS_SETUP + 19);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort cs_n", 32'(cs_n), 1);
        check("abort sck", 32'(sck), 0);
        check("abort busy", 32'(busy), 0);
        check("abort temp_raw", 32'(temp_raw), 0);
        run(10);
        check("abort valid pulses", 32'(vld_cnt - v0), 0);
        next_word = 16'h1A40;
        s0 = sck_rise; v0 = vld_cnt;
        pulse_start();
        run(80);
        check("post-abort sck pulses", 32'(sck_rise - s0), 16);
`ifndef LM70_SPI_SEQUENCER_AVG_EN
        check("post-abort valid pulses", 32'(vld_cnt - v0), 1);
        check("post-abort temp_raw", 32'(temp_raw), 32'h1A40);
`endif

        // Periodic requests: every request pends during a frame, frames 73 apart.
        f0 = starts.size();
        auto_en = 1'b1;
        for (int i = 0; i < 507; i++) begin
            next_word = 16'($urandom);
            step();
        end
        auto_en = 1'b0;
        run(80);
        check("auto frame count", 32'(starts.size() - f0), 7);
        for (int i = f0 + 1; i < starts.size(); i++)
            check("auto frame spacing", 32'(starts[i] - starts[i-1]), T_TOTAL + 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 16) == 0;
            next_word = 16'($urandom);
            if (($urandom % 200) == 0) auto_en = ~auto_en;
            rst = ($urandom % 700) == 0;
            step();
        end
        rst = 1'b0; start = 1'b0; auto_en = 1'b0;
        run(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
